// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types, constants and helpers for the buffered UART transmitter.
//   parity_e         : parity mode of a frame (none / odd / even)
//   tx_state_e       : states of the transmit framing FSM
//   UART_DEFAULT_DIV : default clocks-per-bit, taken from `UART_DIV
//   MAX_DATA_W       : widest supported data field
//   parity_bit()     : parity bit for a data word under a given mode
// ---------------------------------------------------------------------------
`ifndef UART_DIV
`define UART_DIV 16
`endif

package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_ODD,
    PAR_EVEN
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } tx_state_e;

  localparam int UART_DEFAULT_DIV = `UART_DIV;

  // Narrower words are zero-extended to this width before parity is taken;
  // the extra zeros leave the XOR unchanged.
  localparam int MAX_DATA_W = 9;

  // Even parity is the plain XOR of the data bits, odd parity its inverse.
  function automatic logic parity_bit(parity_e mode, logic [MAX_DATA_W-1:0] data);
    logic x;
    x = ^data;
    case (mode)
      PAR_EVEN: return x;
      PAR_ODD:  return ~x;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// ---------------------------------------------------------------------------
// uart_fifo
// Synchronous FIFO buffering words ahead of the serialiser. The head word is
// presented combinationally on rdata whenever the FIFO is non-empty.
// Ports:
//   clk_i  : clock, all state on the rising edge
//   rst_i  : asynchronous active-high reset, empties the FIFO
//   srst_i : synchronous reset, empties the FIFO at the next edge and wins
//            over a simultaneous push or pop
//   push   : write wdata at the tail (ignored while full)
//   wdata  : write data
//   pop    : drop the head word (ignored while empty)
//   rdata  : head word
//   full   : level == DEPTH
//   empty  : level == 0
//   level  : current occupancy
// ---------------------------------------------------------------------------
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           srst_i,
  input  logic                           push,
  input  logic [WIDTH-1:0]               wdata,
  input  logic                           pop,
  output logic [WIDTH-1:0]               rdata,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  // Pointers carry one wrap bit above the address so that a completely full
  // FIFO and an empty one differ even though their addresses match.
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign level   = LW'(wptr_q - rptr_q);
  assign full    = (level == LW'(DEPTH));
  assign empty   = (wptr_q == rptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr_q[AW-1:0]];

  // Pointer update; both resets clear the pointers, which is all it takes to
  // discard the stored words.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (srst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// UART transmitter fed by an internal FIFO. Frames are start bit, DATA_W data
// bits LSB first, optional parity bit and STOP_BITS stop bits; every bit lasts
// CLKDIV clocks. A new frame only starts while cts_i is high, and frames run
// back to back while words are queued.
// Ports:
//   clk_i     : clock, all logic on the rising edge
//   rst_i     : asynchronous active-high reset
//   srst_i    : synchronous soft reset, same effect as rst_i at the next edge
//   in_val_i  : write request
//   in_data_i : write data
//   in_rdy_o  : FIFO can take a word this cycle
//   cts_i     : clear-to-send, sampled only when a frame is about to start
//   uart_tx_o : registered serial line, idle high
//   busy_o    : frame in progress or words still queued
//   level_o   : FIFO occupancy
// ---------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int      CLKDIV     = UART_DEFAULT_DIV,
  parameter int      DATA_W     = 8,
  parameter int      FIFO_DEPTH = 16,
  parameter parity_e PARITY     = PAR_NONE,
  parameter int      STOP_BITS  = 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              srst_i,
  input  logic                              in_val_i,
  input  logic [DATA_W-1:0]                 in_data_i,
  output logic                              in_rdy_o,
  input  logic                              cts_i,
  output logic                              uart_tx_o,
  output logic                              busy_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level_o
);

  localparam int DIV_W = $clog2(CLKDIV);
  localparam int BIT_W = $clog2(DATA_W);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKDIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_e         state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bitcnt_q, bitcnt_d;
  logic              stopcnt_q, stopcnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;

  logic              div_wrap;
  logic              start_frame;
  logic              fifo_push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;

  // Ready deliberately ignores a pop in the same cycle, so a full FIFO never
  // takes a word even while the serialiser is draining it.
  assign in_rdy_o  = !fifo_full && !srst_i;
  assign fifo_push = in_val_i && in_rdy_o;
  assign div_wrap  = (div_q == DIV_LAST);
  assign uart_tx_o = tx_q;
  assign busy_o    = (state_q != IDLE) || (level_o != '0);

  uart_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .srst_i (srst_i),
    .push   (fifo_push),
    .wdata  (in_data_i),
    .pop    (start_frame),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (level_o)
  );

  // State and datapath registers. A soft reset behaves exactly like the
  // asynchronous one, cutting any frame short and driving the line high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bitcnt_q  <= '0;
      stopcnt_q <= 1'b0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
    end else if (srst_i) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bitcnt_q  <= '0;
      stopcnt_q <= 1'b0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bitcnt_q  <= bitcnt_d;
      stopcnt_q <= stopcnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
    end
  end

  // Next-state logic. A frame starts from IDLE, or straight out of the last
  // stop bit so consecutive frames leave no idle gap; either way the head word
  // is popped on that same edge. cts_i only matters at these two points.
  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && cts_i) begin
          state_d     = START;
          start_frame = 1'b1;
        end
      end
      START: begin
        if (div_wrap) state_d = DATA;
      end
      DATA: begin
        if (div_wrap && (bitcnt_q == BIT_LAST)) begin
          state_d = (PARITY == PAR_NONE) ? STOP : PAR;
        end
      end
      PAR: begin
        if (div_wrap) state_d = STOP;
      end
      STOP: begin
        if (div_wrap && (stopcnt_q == STOP_LAST)) begin
          if (!fifo_empty && cts_i) begin
            state_d     = START;
            start_frame = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and line value. The line is registered, so the value computed
  // here is the one belonging to the state being entered; in DATA that is the
  // LSB of the shift register after any shift taken on this edge.
  always_comb begin
    div_d     = div_q;
    bitcnt_d  = bitcnt_q;
    stopcnt_d = stopcnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    tx_d      = 1'b1;

    if (start_frame) begin
      div_d     = '0;
      bitcnt_d  = '0;
      stopcnt_d = 1'b0;
      shreg_d   = fifo_rdata;
      par_d     = parity_bit(PARITY, MAX_DATA_W'(fifo_rdata));
    end else if (state_q != IDLE) begin
      div_d = div_wrap ? '0 : div_q + 1'b1;
      if (div_wrap && (state_q == DATA)) begin
        shreg_d  = shreg_q >> 1;
        bitcnt_d = bitcnt_q + 1'b1;
      end
      if (div_wrap && (state_q == STOP)) begin
        stopcnt_d = stopcnt_q + 1'b1;
      end
    end

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PAR:     tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

endmodule
